// File: rtl/pmic_i2c_pkg.sv
// pmic_i2c_pkg
// Shared definitions for the PMIC I2C path (i2c_listen -> i2c_txn_framer ->
// pmic_core): framer state encoding, decoded-byte field positions, the
// default PMIC device address and the transaction record width.
// No ports (package).
package pmic_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_REG  = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4,
    ST_EMIT = 3'd5
  } state_t;

  // Field positions inside the 9-bit decoded byte word.
  localparam int DATA_MSB = 8;
  localparam int DATA_LSB = 1;
  localparam int RW_BIT   = 1;
  localparam int NACK_BIT = 0;

  localparam logic [6:0] PMIC_DEV_ADDR = 7'h4A;
  localparam int         DEF_MAX_DATA  = 4;

  // addr + rw + reg + len + data lanes + nack + overflow
  function automatic int rec_width(input int max_data);
    return 7 + 1 + 8 + $clog2(max_data + 1) + 8 * max_data + 2;
  endfunction

  localparam int REC_W = rec_width(DEF_MAX_DATA);

endpackage

// File: rtl/i2c_txn_framer_if.sv
// i2c_txn_framer_if
// Bundles the decoded byte stream coming in and the transaction record
// going out of the framer.
//   byte_in/byte_ready/sop/eot : decoded stream from i2c_listen
//   txn_valid/txn_ready        : record handshake with pmic_core
//   txn_*                      : record fields
//   drop_count                 : bytes lost while a record is held
// modport master = framer side, modport slave = producer/consumer side.
interface i2c_txn_framer_if #(
  parameter int MAX_DATA = pmic_i2c_pkg::DEF_MAX_DATA
);
  localparam int LEN_W = $clog2(MAX_DATA + 1);

  logic [8:0]            byte_in;
  logic                  byte_ready;
  logic                  sop;
  logic                  eot;
  logic                  txn_valid;
  logic                  txn_ready;
  logic [6:0]            txn_addr;
  logic                  txn_rw;
  logic [7:0]            txn_reg;
  logic [LEN_W-1:0]      txn_len;
  logic [8*MAX_DATA-1:0] txn_data;
  logic                  txn_nack;
  logic                  txn_overflow;
  logic [7:0]            drop_count;

  modport master (
    input  byte_in, byte_ready, sop, eot, txn_ready,
    output txn_valid, txn_addr, txn_rw, txn_reg, txn_len, txn_data,
           txn_nack, txn_overflow, drop_count
  );

  modport slave (
    output byte_in, byte_ready, sop, eot, txn_ready,
    input  txn_valid, txn_addr, txn_rw, txn_reg, txn_len, txn_data,
           txn_nack, txn_overflow, drop_count
  );
endinterface

// File: rtl/i2c_txn_framer.sv
// i2c_txn_framer
// Assembles one I2C transaction (address, R/W, register offset, up to
// MAX_DATA data bytes, NACK/overflow flags) from the decoded byte stream and
// presents it as a record over a valid/ready handshake.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : i2c_txn_framer_if.master (byte stream in, record out)
module i2c_txn_framer
  import pmic_i2c_pkg::*;
#(
  parameter int         MAX_DATA    = 4,
  parameter logic [6:0] DEV_ADDR    = PMIC_DEV_ADDR,
  parameter bit         ADDR_FILTER = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  i2c_txn_framer_if.master  bus
);

  localparam int               LEN_W   = $clog2(MAX_DATA + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_DATA);

  state_t                r_state, w_state;
  logic [6:0]            r_addr,  w_addr;
  logic                  r_rw,    w_rw;
  logic [7:0]            r_reg,   w_reg;
  logic [LEN_W-1:0]      r_len,   w_len;
  logic [8*MAX_DATA-1:0] r_data,  w_data;
  logic                  r_nack,  w_nack;
  logic                  r_ovf,   w_ovf;
  logic                  r_pend,  w_pend;   // START seen while emitting
  logic                  r_comb,  w_comb;   // write-reg + repeated START
  logic                  r_done,  w_done;   // address byte NACKed, await STOP
  logic [7:0]            r_drop,  w_drop;
  logic                  r_valid, w_valid;

  // Next-state/next-record logic. Events are applied in the order
  // byte_ready, eot, sop so a byte strobed with sop lands in the old frame.
  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_rw    = r_rw;
    w_reg   = r_reg;
    w_len   = r_len;
    w_data  = r_data;
    w_nack  = r_nack;
    w_ovf   = r_ovf;
    w_pend  = r_pend;
    w_comb  = r_comb;
    w_done  = r_done;
    w_drop  = r_drop;

    if (bus.byte_ready) begin
      case (w_state)
        ST_ADDR: begin
          if (!w_done) begin
            w_addr = bus.byte_in[DATA_MSB:RW_BIT+1];
            w_rw   = bus.byte_in[RW_BIT];
            // A combined read keeps the offset (and flags) of its write half.
            if (!w_comb) begin
              w_data = '0;
              w_len  = '0;
              w_reg  = 8'h00;
              w_nack = 1'b0;
              w_ovf  = 1'b0;
            end else begin
              w_reg  = r_reg;
            end
            if (ADDR_FILTER && (bus.byte_in[DATA_MSB:RW_BIT+1] != DEV_ADDR)) begin
              w_state = ST_SKIP;
            end else if (bus.byte_in[NACK_BIT]) begin
              w_nack = 1'b1;
              w_done = 1'b1;
            end else if (bus.byte_in[RW_BIT]) begin
              w_state = ST_DATA;
            end else begin
              w_state = ST_REG;
            end
          end else begin
            w_done = 1'b1;
          end
        end
        ST_REG: begin
          w_reg   = bus.byte_in[DATA_MSB:DATA_LSB];
          w_nack  = w_nack | bus.byte_in[NACK_BIT];
          w_state = ST_DATA;
        end
        ST_DATA: begin
          if (w_len < LEN_MAX) begin
            w_data[8*int'(w_len) +: 8] = bus.byte_in[DATA_MSB:DATA_LSB];
            w_len = w_len + LEN_W'(1);
          end else begin
            w_ovf = 1'b1;
          end
          // Master NACK on the last read byte is normal, so only writes count.
          if (!w_rw) begin
            w_nack = w_nack | bus.byte_in[NACK_BIT];
          end else begin
            w_nack = w_nack;
          end
        end
        ST_EMIT: begin
          if (w_drop != 8'hFF) begin
            w_drop = w_drop + 8'd1;
          end else begin
            w_drop = w_drop;
          end
        end
        default: begin
          w_state = w_state;
        end
      endcase
    end else begin
      w_state = w_state;
    end

    if (bus.eot) begin
      case (w_state)
        ST_ADDR: w_state = w_done ? ST_EMIT : ST_IDLE;
        ST_REG:  w_state = ST_EMIT;
        ST_DATA: w_state = ST_EMIT;
        ST_SKIP: w_state = ST_IDLE;
        default: w_state = w_state;
      endcase
    end else begin
      w_state = w_state;
    end

    if (bus.sop) begin
      case (w_state)
        ST_ADDR: begin
          if (w_done) begin
            w_pend  = 1'b1;
            w_state = ST_EMIT;
          end else begin
            w_comb  = 1'b0;
            w_state = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (!w_rw && (w_len == '0)) begin
            w_comb  = 1'b1;
            w_done  = 1'b0;
            w_state = ST_ADDR;
          end else begin
            w_pend  = 1'b1;
            w_state = ST_EMIT;
          end
        end
        ST_EMIT: begin
          w_pend = 1'b1;
        end
        default: begin
          // IDLE, REG, SKIP: fresh address phase
          w_comb  = 1'b0;
          w_done  = 1'b0;
          w_state = ST_ADDR;
        end
      endcase
    end else begin
      w_state = w_state;
    end

    // Handshake only for a record that was already presented this cycle.
    if ((r_state == ST_EMIT) && bus.txn_ready) begin
      w_comb = 1'b0;
      if (w_pend) begin
        w_pend  = 1'b0;
        w_done  = 1'b0;
        w_state = ST_ADDR;
      end else begin
        w_state = ST_IDLE;
      end
    end else begin
      w_comb = w_comb;
    end

    w_valid = (w_state == ST_EMIT);
  end

  // State and record registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= 7'h00;
      r_rw    <= 1'b0;
      r_reg   <= 8'h00;
      r_len   <= '0;
      r_data  <= '0;
      r_nack  <= 1'b0;
      r_ovf   <= 1'b0;
      r_pend  <= 1'b0;
      r_comb  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_rw    <= w_rw;
      r_reg   <= w_reg;
      r_len   <= w_len;
      r_data  <= w_data;
      r_nack  <= w_nack;
      r_ovf   <= w_ovf;
      r_pend  <= w_pend;
      r_comb  <= w_comb;
      r_done  <= w_done;
      r_drop  <= w_drop;
      r_valid <= w_valid;
    end
  end

  assign bus.txn_valid    = r_valid;
  assign bus.txn_addr     = r_addr;
  assign bus.txn_rw       = r_rw;
  assign bus.txn_reg      = r_reg;
  assign bus.txn_len      = r_len;
  assign bus.txn_data     = r_data;
  assign bus.txn_nack     = r_nack;
  assign bus.txn_overflow = r_ovf;
  assign bus.drop_count   = r_drop;

endmodule

// File: tb/tb_i2c_txn_framer.sv
// tb_i2c_txn_framer
// Directed self-checking bench for i2c_txn_framer. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge.
module tb_i2c_txn_framer;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  i2c_txn_framer_if #(.MAX_DATA(4)) bus ();

  i2c_txn_framer #(
    .MAX_DATA(4),
    .DEV_ADDR(7'h4A),
    .ADDR_FILTER(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; pulses last exactly one cycle.
  task automatic drive(input logic br, input logic [8:0] b, input logic s, input logic e);
    bus.byte_ready = br;
    bus.byte_in    = b;
    bus.sop        = s;
    bus.eot        = e;
    @(negedge clk);
    bus.byte_ready = 1'b0;
    bus.sop        = 1'b0;
    bus.eot        = 1'b0;
  endtask

  task automatic sop_p();                              drive(1'b0, 9'h000, 1'b1, 1'b0); endtask
  task automatic eot_p();                              drive(1'b0, 9'h000, 1'b0, 1'b1); endtask
  task automatic idle();                               drive(1'b0, 9'h000, 1'b0, 1'b0); endtask
  task automatic byte_p(input logic [7:0] d, input logic n); drive(1'b1, {d, n}, 1'b0, 1'b0); endtask

  task automatic test_reset();
    tests_run++; if (bus.txn_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %h want 0", bus.txn_valid); end
    tests_run++; if (bus.txn_addr !== 7'h00) begin fails++; $display("FAIL rst_addr got %h want 00", bus.txn_addr); end
    tests_run++; if (bus.txn_data !== 32'h0) begin fails++; $display("FAIL rst_data got %h want 0", bus.txn_data); end
    tests_run++; if (bus.drop_count !== 8'h00) begin fails++; $display("FAIL rst_drop got %h want 00", bus.drop_count); end
  endtask

  task automatic test_simple_write();
    bus.txn_ready = 1'b1;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h22, 1'b0); byte_p(8'h55, 1'b0); eot_p();
    tests_run++; if (bus.txn_valid !== 1'b1) begin fails++; $display("FAIL w_valid got %h want 1", bus.txn_valid); end
    tests_run++; if (bus.txn_addr !== 7'h4A) begin fails++; $display("FAIL w_addr got %h want 4a", bus.txn_addr); end
    tests_run++; if (bus.txn_rw !== 1'b0) begin fails++; $display("FAIL w_rw got %h want 0", bus.txn_rw); end
    tests_run++; if (bus.txn_reg !== 8'h22) begin fails++; $display("FAIL w_reg got %h want 22", bus.txn_reg); end
    tests_run++; if (bus.txn_len !== 3'd1) begin fails++; $display("FAIL w_len got %0d want 1", bus.txn_len); end
    tests_run++; if (bus.txn_data !== 32'h0000_0055) begin fails++; $display("FAIL w_data got %h want 00000055", bus.txn_data); end
    tests_run++; if (bus.txn_nack !== 1'b0) begin fails++; $display("FAIL w_nack got %h want 0", bus.txn_nack); end
    idle();
    tests_run++; if (bus.txn_valid !== 1'b0) begin fails++; $display("FAIL w_valid_drop got %h want 0", bus.txn_valid); end
  endtask

  task automatic test_combined_read();
    bus.txn_ready = 1'b1;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h10, 1'b0);
    sop_p(); byte_p(8'h95, 1'b0); byte_p(8'hAB, 1'b0); byte_p(8'hCD, 1'b1); eot_p();
    tests_run++; if (bus.txn_valid !== 1'b1) begin fails++; $display("FAIL c_valid got %h want 1", bus.txn_valid); end
    tests_run++; if (bus.txn_rw !== 1'b1) begin fails++; $display("FAIL c_rw got %h want 1", bus.txn_rw); end
    tests_run++; if (bus.txn_reg !== 8'h10) begin fails++; $display("FAIL c_reg got %h want 10", bus.txn_reg); end
    tests_run++; if (bus.txn_len !== 3'd2) begin fails++; $display("FAIL c_len got %0d want 2", bus.txn_len); end
    tests_run++; if (bus.txn_data !== 32'h0000_CDAB) begin fails++; $display("FAIL c_data got %h want 0000cdab", bus.txn_data); end
    tests_run++; if (bus.txn_nack !== 1'b0) begin fails++; $display("FAIL c_nack got %h want 0", bus.txn_nack); end
    idle();
  endtask

  task automatic test_overflow();
    bus.txn_ready = 1'b1;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h01, 1'b0);
    byte_p(8'h11, 1'b0); byte_p(8'h22, 1'b0); byte_p(8'h33, 1'b0);
    byte_p(8'h44, 1'b0); byte_p(8'h55, 1'b0); byte_p(8'h66, 1'b0); eot_p();
    tests_run++; if (bus.txn_len !== 3'd4) begin fails++; $display("FAIL o_len got %0d want 4", bus.txn_len); end
    tests_run++; if (bus.txn_data !== 32'h4433_2211) begin fails++; $display("FAIL o_data got %h want 44332211", bus.txn_data); end
    tests_run++; if (bus.txn_overflow !== 1'b1) begin fails++; $display("FAIL o_ovf got %h want 1", bus.txn_overflow); end
    idle();
  endtask

  task automatic test_addr_nack();
    bus.txn_ready = 1'b1;
    sop_p(); byte_p(8'h94, 1'b1); eot_p();
    tests_run++; if ({bus.txn_valid, bus.txn_nack, bus.txn_len} !== 5'b11_000) begin fails++; $display("FAIL an_rec got %b want 11000", {bus.txn_valid, bus.txn_nack, bus.txn_len}); end
    idle();
    // address probe: address byte only, then STOP
    sop_p(); byte_p(8'h94, 1'b0); eot_p();
    tests_run++; if ({bus.txn_valid, bus.txn_nack, bus.txn_len, bus.txn_reg} !== {5'b10_000, 8'h00}) begin fails++; $display("FAIL probe_rec got %h want %h", {bus.txn_valid, bus.txn_nack, bus.txn_len, bus.txn_reg}, {5'b10_000, 8'h00}); end
    idle();
  endtask

  task automatic test_filter();
    logic seen;
    bus.txn_ready = 1'b1;
    seen = 1'b0;
    sop_p(); byte_p(8'h78, 1'b0); byte_p(8'h00, 1'b0); eot_p();
    seen = seen | bus.txn_valid;
    for (int i = 0; i < 3; i++) begin idle(); seen = seen | bus.txn_valid; end
    tests_run++; if (seen !== 1'b0) begin fails++; $display("FAIL f_filtered got %h want 0", seen); end
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h05, 1'b0); byte_p(8'hAA, 1'b0); eot_p();
    tests_run++; if (bus.txn_valid !== 1'b1) begin fails++; $display("FAIL f_valid got %h want 1", bus.txn_valid); end
    tests_run++; if ({bus.txn_addr, bus.txn_reg, bus.txn_data} !== {7'h4A, 8'h05, 32'h0000_00AA}) begin fails++; $display("FAIL f_rec got %h want %h", {bus.txn_addr, bus.txn_reg, bus.txn_data}, {7'h4A, 8'h05, 32'h0000_00AA}); end
    idle();
  endtask

  task automatic test_back_to_back();
    bus.txn_ready = 1'b1;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h40, 1'b0);
    drive(1'b1, {8'h11, 1'b0}, 1'b1, 1'b0);   // byte with sop belongs to the old frame
    tests_run++; if ({bus.txn_valid, bus.txn_reg, bus.txn_len, bus.txn_data} !== {1'b1, 8'h40, 3'd1, 32'h0000_0011}) begin fails++; $display("FAIL b1_rec got %h want %h", {bus.txn_valid, bus.txn_reg, bus.txn_len, bus.txn_data}, {1'b1, 8'h40, 3'd1, 32'h0000_0011}); end
    idle();
    byte_p(8'h94, 1'b0); byte_p(8'h41, 1'b0); byte_p(8'h22, 1'b0); eot_p();
    tests_run++; if ({bus.txn_valid, bus.txn_reg, bus.txn_len, bus.txn_data} !== {1'b1, 8'h41, 3'd1, 32'h0000_0022}) begin fails++; $display("FAIL b2_rec got %h want %h", {bus.txn_valid, bus.txn_reg, bus.txn_len, bus.txn_data}, {1'b1, 8'h41, 3'd1, 32'h0000_0022}); end
    tests_run++; if (bus.drop_count !== 8'h00) begin fails++; $display("FAIL b_drop got %h want 00", bus.drop_count); end
    idle();
  endtask

  task automatic test_backpressure();
    logic bad;
    bus.txn_ready = 1'b0;
    bad = 1'b0;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h07, 1'b0); byte_p(8'h99, 1'b0); eot_p();
    for (int i = 0; i < 50; i++) begin
      idle();
      if ({bus.txn_valid, bus.txn_addr, bus.txn_reg, bus.txn_len, bus.txn_data} !== {1'b1, 7'h4A, 8'h07, 3'd1, 32'h0000_0099}) bad = 1'b1;
    end
    tests_run++; if (bad !== 1'b0) begin fails++; $display("FAIL bp_stable got %h want 0", bad); end
    byte_p(8'hEE, 1'b0); byte_p(8'hEF, 1'b0); sop_p();
    tests_run++; if (bus.drop_count !== 8'd2) begin fails++; $display("FAIL bp_drop got %0d want 2", bus.drop_count); end
    tests_run++; if ({bus.txn_valid, bus.txn_data} !== {1'b1, 32'h0000_0099}) begin fails++; $display("FAIL bp_hold got %h want %h", {bus.txn_valid, bus.txn_data}, {1'b1, 32'h0000_0099}); end
    bus.txn_ready = 1'b1;
    idle();
    tests_run++; if (bus.txn_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %h want 0", bus.txn_valid); end
    // pending START: next bytes go straight into the address phase
    byte_p(8'h94, 1'b0); byte_p(8'h33, 1'b0); eot_p();
    tests_run++; if ({bus.txn_valid, bus.txn_reg, bus.txn_len} !== {1'b1, 8'h33, 3'd0}) begin fails++; $display("FAIL bp_pending got %h want %h", {bus.txn_valid, bus.txn_reg, bus.txn_len}, {1'b1, 8'h33, 3'd0}); end
    idle();
  endtask

  task automatic test_drop_saturate();
    bus.txn_ready = 1'b0;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h01, 1'b0); eot_p();
    for (int i = 0; i < 300; i++) byte_p(8'h5A, 1'b0);
    tests_run++; if (bus.drop_count !== 8'hFF) begin fails++; $display("FAIL sat_drop got %0d want 255", bus.drop_count); end
    bus.txn_ready = 1'b1;
    idle();
  endtask

  task automatic test_reset_mid();
    bus.txn_ready = 1'b1;
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h01, 1'b0); byte_p(8'h11, 1'b0);
    rst = 1'b1;
    #1;
    tests_run++; if ({bus.txn_addr, bus.txn_reg, bus.txn_len, bus.txn_data, bus.drop_count} !== 58'h0) begin fails++; $display("FAIL rm_async got %h want 0", {bus.txn_addr, bus.txn_reg, bus.txn_len, bus.txn_data, bus.drop_count}); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    sop_p(); byte_p(8'h94, 1'b0); byte_p(8'h02, 1'b0); byte_p(8'h77, 1'b0); eot_p();
    tests_run++; if ({bus.txn_valid, bus.txn_reg, bus.txn_len, bus.txn_data} !== {1'b1, 8'h02, 3'd1, 32'h0000_0077}) begin fails++; $display("FAIL rm_rec got %h want %h", {bus.txn_valid, bus.txn_reg, bus.txn_len, bus.txn_data}, {1'b1, 8'h02, 3'd1, 32'h0000_0077}); end
    idle();
  endtask

  initial begin
    tests_run      = 0;
    fails          = 0;
    rst            = 1'b1;
    bus.byte_in    = 9'h000;
    bus.byte_ready = 1'b0;
    bus.sop        = 1'b0;
    bus.eot        = 1'b0;
    bus.txn_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle();
    test_reset();
    test_simple_write();
    test_combined_read();
    test_overflow();
    test_addr_nack();
    test_filter();
    test_back_to_back();
    test_backpressure();
    test_drop_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/i2c_txn_framer.md
Name: i2c_txn_framer

Overview:
Sits directly downstream of i2c_listen and upstream of pmic_core. Consumes the per-byte decoded stream: 9-bit byte word, ready strobe, start-of-packet (sop) and end-of-transfer (eot) pulses. Assembles each I2C transaction into one record: device address, R/W, register offset, up to MAX_DATA data bytes and NACK/overflow flags. Hands the record to pmic_core over a valid/ready handshake.

Parameters:
MAX_DATA, 4, max data bytes captured per transaction; later bytes are counted as overflow and discarded.
DEV_ADDR, 7'h4A, 7-bit device address accepted when ADDR_FILTER=1.
ADDR_FILTER, 1, 1 = drop transactions to other addresses; 0 = frame all addresses.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
byte_in  in  9  decoded byte; [8:1] = data MSB-first, [0] = ack bit (1 = NACK).
byte_ready  in  1  one-cycle pulse; byte_in valid this cycle.
sop  in  1  one-cycle pulse on START or repeated START.
eot  in  1  one-cycle pulse on STOP.
txn_valid  out  1  record available.
txn_ready  in  1  consumer accepts record.
txn_addr  out  7  device address.
txn_rw  out  1  1 = read.
txn_reg  out  8  register offset (0 when none was sent).
txn_len  out  3  number of captured data bytes, 0..MAX_DATA (width = clog2(MAX_DATA+1)).
txn_data  out  8*MAX_DATA  byte k in [8k+7:8k]; unused lanes are 0.
txn_nack  out  1  any NACK on the address byte, or on a write data/reg byte.
txn_overflow  out  1  more than MAX_DATA data bytes seen.
drop_count  out  8  saturating count of bytes lost while a record is held.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; pending_start=0; combined=0.
- States: IDLE, ADDR, REG, DATA, SKIP, EMIT.
- Same-cycle ordering: byte_ready is processed first, then eot, then sop. A byte strobed with sop belongs to the old frame.
- IDLE:
  - sop -> ADDR.
  - byte_ready/eot ignored.
- ADDR:
  - On byte_ready: capture addr=byte_in[8:2], rw=byte_in[1].
  - Unless combined=1: clear data lanes, len, reg, nack, overflow. If combined=1, reg is kept.
  - Address mismatch with ADDR_FILTER=1 -> SKIP.
  - Address NACK (byte_in[0]=1): nack=1, stay in ADDR-done sub-state; the next eot -> EMIT with len 0.
  - rw=0 -> REG; rw=1 -> DATA.
  - eot before any byte -> IDLE, nothing emitted.
- REG:
  - byte_ready -> reg=byte_in[8:1]; nack|=byte_in[0]; -> DATA.
  - eot with no reg byte -> EMIT (address probe, len 0).
  - sop with no reg byte -> ADDR, fresh.
- DATA:
  - byte_ready with len<MAX_DATA: store in lane len; len++.
  - byte_ready with len==MAX_DATA: overflow=1; byte discarded.
  - Write: nack|=byte_in[0]. Read: NACK ignored, since master NACK on the last byte is normal.
  - eot -> EMIT.
  - sop when rw=0 and len==0 (write-reg then repeated START) -> combined=1, ADDR; the following read reports the kept reg.
  - sop otherwise -> pending_start=1, EMIT.
- SKIP:
  - Bytes ignored.
  - eot -> IDLE.
  - sop -> ADDR, fresh.
- EMIT:
  - txn_valid=1; all txn_* outputs held stable.
  - txn_ready sampled the same cycle; handshake completes when valid&&ready.
  - On handshake: txn_valid=0 next cycle; combined=0.
  - After handshake: pending_start=1 -> ADDR (clear pending_start), else IDLE.
  - While in EMIT: sop sets pending_start; byte_ready increments drop_count (saturates at 255, never wraps); eot ignored.
- Latency: txn_valid rises the cycle after the terminating eot/sop. Minimum one cycle in EMIT when txn_ready is held 1.
- combined is cleared on handshake and on any fresh ADDR entry.

Decomposition:
- Shared package pmic_i2c_pkg holds:
  - state encoding constants.
  - byte field positions: DATA_MSB=8, DATA_LSB=1, RW_BIT=1, NACK_BIT=0.
  - default PMIC device address.
  - record width derived from MAX_DATA.
- i2c_listen and pmic_core import the same field constants.
- No sub-module required. The saturating drop counter is small enough to stay inline.

Test Plan:
1. sop, byte 0x94 (addr 0x4A, W, ACK), 0x22, 0x55, eot, txn_ready=1 -> txn_valid one cycle after eot; addr=0x4A, rw=0, reg=0x22, len=1, data[7:0]=0x55, nack=0.
2. Combined read: sop, 0x94, 0x10, sop, 0x95, 0xAB, 0xCD (last with NACK), eot -> one record: rw=1, reg=0x10, len=2, data=0xCDAB, nack=0.
3. Write with 6 data bytes, MAX_DATA=4 -> len=4, first four bytes in lanes 0..3, overflow=1.
4. Address 0x3C (byte 0x78) with ADDR_FILTER=1 -> no txn_valid; the next 0x4A transaction frames normally.
5. txn_ready=0 for 50 cycles after eot, then 2 byte_ready pulses and a sop -> outputs stable; drop_count=2; after ready, state=ADDR.
6. rst asserted mid-DATA -> outputs 0 immediately; following clean transaction framed correctly.
